// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, divider states and
// constants used by both the ALU wrapper and the iterative divider.
package ex_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_LUI  = 4'd10,
    OP_DIV  = 4'd11,
    OP_DIVU = 4'd12,
    OP_REM  = 4'd13,
    OP_REMU = 4'd14
  } aluop_t;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Absolute value for signed divides; unsigned divides pass straight through.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] value,
                                                input logic is_signed);
    return (is_signed && value[XLEN-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// with the signs re-applied when the result is presented in DONE.
module div_iter
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_t      state;
  div_state_t      state_next;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  work_q;
  logic [XLEN-1:0]  part_rem;
  logic [XLEN-1:0]  div_mag;
  logic             neg_q;
  logic             neg_r;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;
  logic             fits;

  // One restoring step: bring down the next dividend bit and trial-subtract.
  assign shifted = {part_rem, work_q[XLEN-1]};
  assign diff    = shifted - {1'b0, div_mag};
  assign fits    = ~diff[XLEN];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  // Next state: zero divisors skip straight to DONE; flush always wins.
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (start) state_next = (divisor == '0) ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (count == '0) state_next = DIV_DONE;
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (flush) state_next = DIV_IDLE;
  end

  // Datapath registers: operand capture on launch, one iteration per BUSY cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      work_q   <= '0;
      part_rem <= '0;
      div_mag  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (!flush) begin
      case (state)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              work_q   <= DIV_ZERO_QUOTIENT;
              part_rem <= dividend;
              div_mag  <= '0;
              neg_q    <= 1'b0;
              neg_r    <= 1'b0;
              count    <= '0;
            end else begin
              work_q   <= magnitude(dividend, is_signed);
              div_mag  <= magnitude(divisor, is_signed);
              part_rem <= '0;
              neg_q    <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
              neg_r    <= is_signed & dividend[XLEN-1];
              count    <= CNT_W'(DIV_CYCLES - 1);
            end
          end
        end
        DIV_BUSY: begin
          part_rem <= fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
          work_q   <= {work_q[XLEN-2:0], fits};
          if (count != '0) count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs: status flags and sign-corrected results.
  always_comb begin
    busy      = (state == DIV_BUSY);
    done      = (state == DIV_DONE);
    quotient  = neg_q ? -work_q : work_q;
    remainder = neg_r ? -part_rem : part_rem;
  end

endmodule

// File: rtl/ex.sv
// Execute stage: combinational ALU plus an iterative divider, with stall and
// write-enable gating toward the memory-stage register.
module ex
  import ex_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_aluop,
  input  logic [31:0] id_reg1,
  input  logic [31:0] id_reg2,
  input  logic        id_we,
  input  logic [4:0]  id_addr,
  output logic        ex_we,
  output logic [4:0]  ex_addr,
  output logic [31:0] ex_data,
  output logic        stall_req
);

  aluop_t      op;
  logic        is_div;
  logic        is_rem;
  logic        is_signed_div;
  logic        alu_defined;
  logic [31:0] alu_result;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic        div_idle;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  assign op            = aluop_t'(id_aluop);
  assign is_div        = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  assign is_rem        = (op == OP_REM) || (op == OP_REMU);
  assign is_signed_div = (op == OP_DIV) || (op == OP_REM);
  assign div_start     = id_valid & is_div & ~flush;
  assign div_idle      = ~div_busy & ~div_done;

  div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .start     (div_start),
    .is_signed (is_signed_div),
    .dividend  (id_reg1),
    .divisor   (id_reg2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quotient),
    .remainder (div_remainder)
  );

  // Single-cycle ALU; divide codes yield 0 here since their result comes from the divider.
  always_comb begin
    alu_result  = '0;
    alu_defined = 1'b1;
    case (op)
      OP_ADD:  alu_result = id_reg1 + id_reg2;
      OP_SUB:  alu_result = id_reg1 - id_reg2;
      OP_AND:  alu_result = id_reg1 & id_reg2;
      OP_OR:   alu_result = id_reg1 | id_reg2;
      OP_XOR:  alu_result = id_reg1 ^ id_reg2;
      OP_SLT:  alu_result = {31'b0, $signed(id_reg1) < $signed(id_reg2)};
      OP_SLTU: alu_result = {31'b0, id_reg1 < id_reg2};
      OP_SLL:  alu_result = id_reg1 << id_reg2[4:0];
      OP_SRL:  alu_result = id_reg1 >> id_reg2[4:0];
      OP_SRA:  alu_result = $unsigned($signed(id_reg1) >>> id_reg2[4:0]);
      OP_LUI:  alu_result = id_reg2 << 16;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_result = '0;
      default: alu_defined = 1'b0;
    endcase
  end

  // Result mux and write/stall gating; reset and flush suppress both immediately.
  always_comb begin
    ex_addr   = id_addr;
    ex_data   = alu_result;
    ex_we     = 1'b0;
    stall_req = (div_idle & div_start) | div_busy;
    if (div_done && is_div) begin
      ex_data = is_rem ? div_remainder : div_quotient;
      ex_we   = id_we;
    end else if (!is_div && alu_defined) begin
      ex_we = id_we & id_valid;
    end
    if (reset || flush) begin
      ex_we     = 1'b0;
      stall_req = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the execute stage: directed corner cases followed by
// random operations compared against an arithmetic reference model.
module tb_ex;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        id_valid;
  logic [3:0]  id_aluop;
  logic [31:0] id_reg1;
  logic [31:0] id_reg2;
  logic        id_we;
  logic [4:0]  id_addr;
  logic        ex_we;
  logic [4:0]  ex_addr;
  logic [31:0] ex_data;
  logic        stall_req;

  int checks = 0;
  int errors = 0;

  ex #(.DIV_CYCLES(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .id_valid  (id_valid),
    .id_aluop  (id_aluop),
    .id_reg1   (id_reg1),
    .id_reg2   (id_reg2),
    .id_we     (id_we),
    .id_addr   (id_addr),
    .ex_we     (ex_we),
    .ex_addr   (ex_addr),
    .ex_data   (ex_data),
    .stall_req (stall_req)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Reference model: results straight from integer arithmetic on the operands.
  function automatic logic [31:0] model_result(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return 32'(sa >>> b[4:0]);
      4'd10: return {b[15:0], 16'h0000};
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : 32'(sa % sb);
      4'd14: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit model_is_div(input logic [3:0] op);
    return op inside {4'd11, 4'd12, 4'd13, 4'd14};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic we,
                               input logic [4:0] addr);
    id_valid = 1'b1;
    id_aluop = op;
    id_reg1  = a;
    id_reg2  = b;
    id_we    = we;
    id_addr  = addr;
  endtask

  // Issue one instruction (called just after a rising edge) and check its result.
  task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic we, input logic [4:0] addr);
    int   n;
    logic we_seen;
    logic [31:0] exp_data;
    exp_data = model_result(op, a, b);
    applyStimulus(op, a, b, we, addr);
    if (!model_is_div(op)) begin
      @(negedge clk);
      checkOutput({tag, ".data"}, ex_data, exp_data);
      checkOutput({tag, ".we"}, 32'(ex_we), (op <= 4'd14) ? 32'(we) : 32'd0);
      checkOutput({tag, ".stall"}, 32'(stall_req), 32'd0);
    end else begin
      n = 0;
      we_seen = 1'b0;
      @(negedge clk);
      while (stall_req === 1'b1 && n < 40) begin
        if (ex_we !== 1'b0) we_seen = 1'b1;
        n++;
        @(negedge clk);
      end
      checkOutput({tag, ".stall_cycles"}, 32'(n), (b == 0) ? 32'd1 : 32'd33);
      checkOutput({tag, ".we_while_stalled"}, 32'(we_seen), 32'd0);
      checkOutput({tag, ".data"}, ex_data, exp_data);
      checkOutput({tag, ".we"}, 32'(ex_we), 32'(we));
      checkOutput({tag, ".addr"}, 32'(ex_addr), 32'(addr));
    end
    @(posedge clk);
    #1;
    id_valid = 1'b0;
  endtask

  initial begin
    logic we_seen;
    logic [3:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    reset    = 1'b1;
    flush    = 1'b0;
    applyStimulus(4'd12, 32'd100, 32'd7, 1'b1, 5'd9);
    #2;
    checkOutput("reset.stall", 32'(stall_req), 32'd0);
    checkOutput("reset.we", 32'(ex_we), 32'd0);
    checkOutput("reset.addr", 32'(ex_addr), 32'd9);
    id_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    runOp("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd1);
    runOp("sra", 4'd9, 32'h8000_0000, 32'd4, 1'b1, 5'd2);
    runOp("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd3);
    runOp("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd4);
    runOp("lui", 4'd10, 32'd0, 32'h0000_ABCD, 1'b1, 5'd5);
    runOp("undef", 4'd15, 32'd3, 32'd4, 1'b1, 5'd6);
    runOp("divu", 4'd12, 32'd100, 32'd7, 1'b1, 5'd7);
    runOp("remu", 4'd14, 32'd100, 32'd7, 1'b1, 5'd8);
    runOp("div_neg", 4'd11, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd9);
    runOp("rem_neg", 4'd13, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd10);
    runOp("div_ovf", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd11);
    runOp("div_zero", 4'd11, 32'd5, 32'd0, 1'b1, 5'd12);
    runOp("rem_zero", 4'd13, 32'd5, 32'd0, 1'b1, 5'd13);

    // Invalid instruction must not write.
    applyStimulus(4'd0, 32'd1, 32'd2, 1'b1, 5'd14);
    id_valid = 1'b0;
    @(negedge clk);
    checkOutput("invalid.we", 32'(ex_we), 32'd0);
    @(posedge clk);
    #1;

    // Flush in BUSY cycle 10.
    applyStimulus(4'd12, 32'd100, 32'd7, 1'b1, 5'd15);
    @(negedge clk);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    checkOutput("flush.stall", 32'(stall_req), 32'd0);
    checkOutput("flush.we", 32'(ex_we), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    id_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush.idle_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    runOp("add_after_flush", 4'd0, 32'd20, 32'd22, 1'b1, 5'd16);

    // Reset in BUSY cycle 20; the aborted divide must never write.
    applyStimulus(4'd11, 32'd1000, 32'd3, 1'b1, 5'd17);
    @(negedge clk);
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset.stall", 32'(stall_req), 32'd0);
    checkOutput("midreset.we", 32'(ex_we), 32'd0);
    @(posedge clk);
    #1;
    id_valid = 1'b0;
    reset    = 1'b0;
    we_seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ex_we !== 1'b0 || stall_req !== 1'b0) we_seen = 1'b1;
    end
    checkOutput("midreset.no_write", 32'(we_seen), 32'd0);
    @(posedge clk);
    #1;
    runOp("add_after_reset", 4'd1, 32'd5, 32'd7, 1'b1, 5'd18);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      runOp("random", rop, ra, rb, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage CPU pipeline, sitting between decode and the memory-stage register, which it drives through `ex_we`/`ex_addr`/`ex_data`. Single-cycle ALU operations are combinational. Divide and remainder run on an internal iterative radix-2 divider. While the divider is working, `stall_req` freezes the upstream stages.

## Interface
- `DIV_CYCLES`, 32: iterations per divide; equals the operand width.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `flush` in 1: cancels the current instruction, including any in-flight divide.
- `id_valid` in 1: decode presents a valid instruction.
- `id_aluop` in 4: operation code; encodings are in `ex_pkg`.
- `id_reg1` in 32: operand A (dividend for divides).
- `id_reg2` in 32: operand B (divisor; shift amount is `[4:0]`).
- `id_we` in 1: instruction writes the register file.
- `id_addr` in 5: destination register.
- `ex_we` out 1: write enable toward the memory stage.
- `ex_addr` out 5: destination toward the memory stage.
- `ex_data` out 32: result toward the memory stage.
- `stall_req` out 1: holds decode and fetch; `id_*` must stay stable while it is 1.

## Operation
- Ops: ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA, LUI (`id_reg2<<16`), DIV, DIVU, REM, REMU. Undefined codes give `ex_data`=0 and `ex_we`=0.
- Arithmetic wraps modulo 2^32, with no overflow trap.
- Non-divide ops: `ex_we`=`id_we & id_valid & !flush`, `ex_addr`=`id_addr`, `ex_data`=ALU result, all combinational, with `stall_req`=0.
- Divider FSM states IDLE, BUSY, DONE:
  - IDLE to BUSY: `id_valid` and a divide op and nonzero divisor and `!flush`. Latch |A| and |B| (signed ops use magnitudes) and the result signs; counter=`DIV_CYCLES-1`.
  - IDLE to DONE: divide op with divisor 0. Result: quotient 0xFFFFFFFF, remainder = A, for both signed and unsigned.
  - BUSY: each cycle shift in one dividend bit, trial-subtract, and set one quotient bit. Counter decrements; at 0, go to DONE.
  - DONE: apply signs (quotient negative if signs differ; remainder takes the dividend's sign). Present the result and go to IDLE.
  - Any state to IDLE on `flush`.
- DIV 0x80000000 / -1 gives quotient 0x80000000 and remainder 0. No special case is needed.
- `stall_req`=1 when (IDLE and a divide launches) or BUSY; it is 0 in DONE.
- `ex_we`=0 in IDLE-launch and BUSY. In DONE, `ex_we`=`id_we & !flush` and `ex_data`=quotient or remainder per op.
- The instruction in `id_*` during DONE is the same divide. Because the FSM leaves DONE for IDLE, it must not relaunch on the same instruction.

## Timing
- Non-divide latency: 0 cycles, combinational into the memory-stage register.
- Divide with nonzero divisor is issued in cycle 0, runs BUSY in cycles 1–32, and presents its result in DONE at cycle 33. `stall_req` is high for cycles 0–32, 33 cycles total.
- Divide by zero has `stall_req` high in cycle 0 and the result in cycle 1.
- `flush` in any cycle forces `ex_we`=0 and `stall_req`=0 combinationally in that cycle; the FSM is IDLE next edge.
- Reset (asynchronous, any time, including mid-divide): FSM IDLE, counter 0, divider registers 0. While `reset`=1, `ex_we`=0 and `stall_req`=0; `ex_addr` and `ex_data` follow the combinational path. A divide in flight at reset is discarded.

## Structure
- `ex_pkg` holds:
  - the `id_aluop` encodings;
  - the divider state enum {IDLE, BUSY, DONE};
  - the width constant 32;
  - the divide-by-zero quotient constant.
- Sub-module `div_iter`: FSM, counter, partial remainder and quotient registers, and sign fix-up. It has a start/op/operands input and busy/done/quotient/remainder outputs.
- `ex` holds the combinational ALU, result muxing and `stall_req`/`ex_we` gating.

## Test plan
- ADD 0x7FFFFFFF + 1: `ex_data`=0x80000000 and `ex_we`=1 in the same cycle, with `stall_req` never set.
- SRA 0x80000000 by 4 gives 0xF8000000; SLT -1,1 gives 1; SLTU -1,1 gives 0.
- DIVU 100/7:
  - `stall_req` is high for exactly 33 cycles.
  - At cycle 33, `ex_data`=14 with `ex_we`=1.
  - REMU 100/7 gives 2.
- DIV -7/2 gives 0xFFFFFFFD (-3); REM -7/2 gives 0xFFFFFFFF (-1); DIV 0x80000000/-1 gives 0x80000000.
- DIV 5/0: `stall_req` is high for 1 cycle, then `ex_data`=0xFFFFFFFF; REM 5/0 gives 5.
- Abort paths:
  - Assert `flush` at BUSY cycle 10: `stall_req` drops that cycle and `ex_we` stays 0. A following ADD completes normally.
  - Assert `reset` at BUSY cycle 20: all state clears and no write is issued.
